// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the 1101 pattern transmitter and the detector benches.
package pattern_tx_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_PAT_W  = 4;
   localparam int unsigned DEF_GAP    = 2;

   localparam logic [3:0] SYNC_1101 = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_GAP
   } tx_state_e;

   // Bits needed to count up to the largest of the three phase lengths.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 1) m = 1;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pattern_1101_tx_piso_shift.sv
// Parallel-in/serial-out shift register, MSB out first, zero-filled from the LSB.
module piso_shift #(
   parameter int unsigned W = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         dout
);

   logic [W-1:0] sr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= {sr[W-2:0], 1'b0};
      end
   end

   assign dout = sr[W-1];

endmodule

// File: rtl/pattern_1101_tx.sv
// Frame transmitter: preamble, MSB-first payload, then guard zeros on serial line x.
module pattern_1101_tx
   import pattern_tx_pkg::*;
#(
   parameter int unsigned       DATA_W  = DEF_DATA_W,
   parameter int unsigned       PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(SYNC_1101),
   parameter int unsigned       GAP     = DEF_GAP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              x,
   output logic              busy,
   output logic              sof,
   output logic              eof
);

   localparam int unsigned CNT_W = cnt_width(PAT_W, DATA_W, GAP);
   localparam int unsigned SR_W  = PAT_W + DATA_W;

   localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'((DATA_W > 1) ? DATA_W - 2 : 0);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

   tx_state_e        state;
   logic [CNT_W-1:0] cnt;
   logic             load_c;
   logic             shift_c;

   // x comes straight from the shift register flop; it drains to zero by the gap.
   assign load_c  = (state == ST_IDLE) && in_valid;
   assign shift_c = (state == ST_PRE) || (state == ST_DATA);

   piso_shift #(
      .W (SR_W)
   ) u_piso (
      .clk   (clk),
      .reset (reset),
      .load  (load_c),
      .shift (shift_c),
      .din   ({PATTERN, in_data}),
      .dout  (x)
   );

   // Frame sequencer; sof/eof are set one edge ahead so they align with x.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         in_ready <= 1'b1;
         busy     <= 1'b0;
         sof      <= 1'b0;
         eof      <= 1'b0;
      end else begin
         sof <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  state    <= ST_PRE;
                  cnt      <= '0;
                  sof      <= 1'b1;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
               end
            end
            ST_PRE: begin
               if (cnt == PAT_LAST) begin
                  state <= ST_DATA;
                  cnt   <= '0;
                  eof   <= (DATA_W == 1);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt == DATA_LAST) begin
                  eof <= 1'b0;
                  cnt <= '0;
                  if (GAP == 0) begin
                     state    <= ST_IDLE;
                     busy     <= 1'b0;
                     in_ready <= 1'b1;
                  end else begin
                     state <= ST_GAP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  eof <= (cnt == DATA_PEN);
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  state    <= ST_IDLE;
                  cnt      <= '0;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_1101_tx.sv
// Scoreboard bench for pattern_1101_tx: frame model in the driver, per-cycle monitor on the negedge.
module tb_pattern_1101_tx;
   import pattern_tx_pkg::*;

   localparam int unsigned DW   = 8;
   localparam int unsigned PW   = 4;
   localparam int unsigned GW   = 2;
   localparam int unsigned FLEN = PW + DW + GW;

   typedef struct {
      int         t;
      logic [7:0] w;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, x, busy, sof, eof;

   int   cyc = 0;
   int   model_free = 0;
   bit   acc_flag = 0;
   bit   abort_pend = 0;
   exp_t q[$];

   int n_checks = 0;
   int n_pass   = 0;

   bit               active = 0;
   int               start = 0;
   logic [FLEN-1:0]  fbits = '0;
   logic [3:0]       hist = 4'b0;
   bit               moore_q = 0;
   int               mealy_hits[$];
   int               moore_hits[$];
   int               sof_log[$];

   pattern_1101_tx dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .x        (x),
      .busy     (busy),
      .sof      (sof),
      .eof      (eof)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
   endtask

   // One clock: the model sees exactly what the DUT sampled at this edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      acc_flag = 0;
      if (!reset) begin
         q.delete();
         model_free = cyc + 1;
         abort_pend = 1;
      end else if (in_valid && cyc >= model_free) begin
         q.push_back('{t: cyc, w: in_data});
         model_free = cyc + FLEN + 1;
         acc_flag = 1;
      end
      #1;
   endtask

   task automatic send(input logic [7:0] w, input bit keep, output int t);
      in_valid = 1'b1;
      in_data  = w;
      t = -1;
      for (int i = 0; i < 40 && t < 0; i++) begin
         tick();
         if (acc_flag) t = cyc;
      end
      if (!keep) in_valid = 1'b0;
      check("send_accepted", 32'(t >= 0), 32'd1);
   endtask

   // Monitor: pops an expected frame when the DUT raises sof, then checks every cycle.
   always @(negedge clk) begin
      logic [4:0] exp_v;
      int         p;
      if (abort_pend) begin
         active = 0;
         abort_pend = 0;
      end
      while (q.size() > 0 && q[0].t < cyc) begin
         check("frame_missing", 32'(q[0].t), 32'(cyc));
         void'(q.pop_front());
      end
      if (sof) begin
         sof_log.push_back(cyc);
         if (q.size() > 0 && q[0].t == cyc) begin
            exp_t e;
            e = q.pop_front();
            fbits  = {SYNC_1101, e.w, {GW{1'b0}}};
            start  = cyc;
            active = 1;
         end else if (!active) begin
            check("unexpected_sof", 32'd1, 32'd0);
         end
      end
      if (active && (cyc - start) >= int'(FLEN)) active = 0;
      if (active) begin
         p = cyc - start;
         exp_v = {fbits[FLEN-1-p], 1'(p == 0), 1'(p == int'(PW + DW - 1)), 1'b1, 1'b0};
      end else begin
         exp_v = 5'b00001;
      end
      check("x_sof_eof_busy_ready", 32'({x, sof, eof, busy, in_ready}), 32'(exp_v));
      // Reference 1101 detectors on the line: Mealy fires on the 4th bit, Moore one cycle later.
      hist = {hist[2:0], x};
      if (moore_q) moore_hits.push_back(cyc);
      moore_q = (hist == 4'b1101);
      if (moore_q) mealy_hits.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t, t2;
      // Reset held for two edges with a pending request.
      reset = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hA5;
      tick();
      tick();
      check("reset_no_frame", 32'(sof_log.size()), 32'd0);
      reset = 1'b1;
      in_valid = 1'b0;
      tick();

      // Single frame.
      sof_log.delete();
      send(8'hA5, 0, t);
      repeat (20) tick();
      check("single_sof_count", 32'(sof_log.size()), 32'd1);

      // Back-to-back with in_valid held.
      sof_log.delete();
      send(8'h3C, 1, t);
      send(8'hC3, 0, t2);
      repeat (20) tick();
      check("b2b_sof_count", 32'(sof_log.size()), 32'd2);
      if (sof_log.size() == 2) check("b2b_sof_spacing", 32'(sof_log[1] - sof_log[0]), 32'd15);

      // Request during busy is ignored.
      sof_log.delete();
      send(8'h5A, 0, t);
      repeat (4) tick();
      in_valid = 1'b1;
      in_data = 8'hFF;
      tick();
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (25) tick();
      check("ignored_sof_count", 32'(sof_log.size()), 32'd1);

      // Abort during the 6th bit, then a clean 00 frame with detector alignment.
      send(8'hA5, 0, t);
      repeat (5) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      mealy_hits.delete();
      moore_hits.delete();
      send(8'h00, 0, t);
      repeat (18) tick();
      check("mealy_hit_count", 32'(mealy_hits.size()), 32'd1);
      if (mealy_hits.size() > 0) check("mealy_hit_cycle", 32'(mealy_hits[0] - t), 32'd3);
      check("moore_hit_count", 32'(moore_hits.size()), 32'd1);
      if (moore_hits.size() > 0) check("moore_hit_cycle", 32'(moore_hits[0] - t), 32'd4);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         reset    = ($urandom_range(0, 63) != 0);
         tick();
      end
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (20) tick();
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pattern_1101_tx.md
# pattern_1101_tx

Serial pattern transmitter: the sending end of the "1101" sequence-detection link. It accepts a parallel data word over a valid/ready handshake and emits one frame on the serial line `x`: the sync preamble (default `1101`), then the word MSB-first, then a run of guard zeros. It drives the `x` input of the `mealy_1101` and `moore_1101` detectors, so frames can be found by the existing receivers.

## Interface
- `DATA_W`, 8: payload width in bits.
- `PAT_W`, 4: preamble width in bits.
- `PATTERN`, 4'b1101: preamble bits, sent MSB-first.
- `GAP`, 2: number of idle `0` bits appended after each frame. 0 is legal.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset. 0 at a rising edge resets the block.
- `in_valid`  in  1  source presents a word.
- `in_data`  in  DATA_W  word to send.
- `in_ready`  out  1  block accepts a word this cycle.
- `x`  out  1  serial line.
- `busy`  out  1  frame or gap in progress.
- `sof`  out  1  high while `x` carries the first preamble bit.
- `eof`  out  1  high while `x` carries the last data bit.

## Operation
- State machine with states IDLE, PRE, DATA and GAP.
  - IDLE: `in_ready`=1, `x`=0. On `in_valid`&&`in_ready` at an edge, latch `in_data`, clear the bit counter and go to PRE.
  - PRE: `x`=`PATTERN[PAT_W-1-cnt]`. After PAT_W cycles go to DATA.
  - DATA: `x`=`word[DATA_W-1-cnt]`. After DATA_W cycles go to GAP, or to IDLE if GAP=0.
  - GAP: `x`=0. After GAP cycles go to IDLE.
- `busy` is high exactly when the state is not IDLE. `in_ready` = !`busy`.
- `in_valid` is ignored while `in_ready`=0. Words are not queued; the source holds `in_valid` until it sees the handshake.
- `in_data` is sampled only at the accepting edge. Later changes have no effect on the frame in progress.
- Reset values: `x`=0, `in_ready`=1, `busy`=0, `sof`=0, `eof`=0, state IDLE.
- Reset mid-frame aborts the frame. At the next edge `x`=0 and the state is IDLE. No partial tail is sent, and the aborted word is lost.
- All outputs are registered; `x` must be glitch-free.
- Bit counter width is `$clog2(max(PAT_W,DATA_W,GAP)+1)`. The counter compares against width-1 and never wraps past the terminal count.
- The block does not screen payload for the pattern. A payload containing `1101` causes extra detector hits; avoiding that is the source's responsibility.

## Timing
- Handshake at edge T gives the first preamble bit on `x` during cycle T+1, with `sof` high in that cycle.
- The last data bit is on `x` during cycle T+PAT_W+DATA_W, with `eof` high in that cycle.
- `in_ready` returns high in cycle T+PAT_W+DATA_W+GAP+1.
- With `in_valid` held high, frames repeat every PAT_W+DATA_W+GAP+1 cycles. That is 15 cycles at the defaults, including one idle `0`.
- Detector alignment at the defaults:
  - `mealy_1101` asserts during cycle T+4, the cycle carrying the 4th preamble bit.
  - `moore_1101` asserts during cycle T+5.

## Structure
- Shared package `pattern_tx_pkg` holds:
  - the state enum (IDLE, PRE, DATA, GAP);
  - `SYNC_1101` = 4'b1101;
  - the default widths. Detector benches reuse `SYNC_1101`.
- One sub-module, `piso_shift`: a parameterized parallel-in/serial-out register with load and shift enables, MSB-out.
  - It is instantiated once, with width PAT_W+DATA_W.
  - It is loaded with {PATTERN, in_data} at accept and shifts once per PRE/DATA cycle.
- The top level keeps the FSM, the bit counter and the `sof`/`eof` flags.

## Test plan
- Reset: hold `reset`=0 for 2 edges with `in_valid`=1 -> `x`=0, `in_ready`=1, `busy`=0, `sof`=0, `eof`=0. No frame starts while reset is held.
- Single frame: `in_data`=8'hA5 with a one-cycle `in_valid` -> `x` reads `1101 10100101 00`, then 0. `sof` is high on cycle 1 and `eof` on cycle 12. `in_ready` is low for 14 cycles.
- Back-to-back: `in_valid` held high with 8'h3C then 8'hC3 -> second `sof` exactly 15 cycles after the first. One idle `0` precedes it.
- Ignored request: a pulse of `in_valid` with 8'hFF while `busy` -> the current frame is unchanged and no extra frame follows.
- Abort: assert reset during the 6th bit of an 8'hA5 frame -> `x`=0 and `in_ready`=1 on the next cycle. A new 8'h00 frame then sends cleanly.
- Loopback: drive `x` into `mealy_1101` and `moore_1101` and send 8'h00 -> exactly one Mealy pulse at cycle T+4 and one Moore pulse at cycle T+5. No other detections.
